// File: rtl/tdm_demux4_if.sv
// Channel-side bundle of the 4-channel TDM demultiplexer: the shared sample
// line on one side and the four registered channels plus status on the other.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             frame_sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [3:0]       ch_valid;
    logic [1:0]       slot;
    logic             locked;
    logic             frame_done;
    logic             sync_err;

    // Link side: drives samples, observes the channel outputs.
    modport master (
        output din, din_valid, frame_sync,
        input  a, b, c, d, ch_valid, slot, locked, frame_done, sync_err
    );

    // Demultiplexer side: consumes samples, drives the channel outputs.
    modport slave (
        input  din, din_valid, frame_sync,
        output a, b, c, d, ch_valid, slot, locked, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of a 4:1 TDM link. Hunts for frame_sync, then steers each
// valid sample into channel a..d by a 2-bit slot counter. All outputs,
// including the strobes, come straight from registers.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    tdm_demux4_if.slave   bus
);
    typedef enum logic [0:0] {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] a_r, b_r, c_r, d_r;
    logic [WIDTH-1:0] a_nxt_s, b_nxt_s, c_nxt_s, d_nxt_s;
    logic [3:0]       ch_valid_r, ch_valid_nxt_s;
    logic [1:0]       slot_r, slot_nxt_s;
    logic             locked_r, locked_nxt_s;
    logic             frame_done_r, frame_done_nxt_s;
    logic             sync_err_r, sync_err_nxt_s;

    // Next-state and next-output decode; strobes default to zero every cycle.
    always_comb begin
        state_nxt_s      = state_r;
        a_nxt_s          = a_r;
        b_nxt_s          = b_r;
        c_nxt_s          = c_r;
        d_nxt_s          = d_r;
        ch_valid_nxt_s   = 4'b0000;
        slot_nxt_s       = slot_r;
        frame_done_nxt_s = 1'b0;
        sync_err_nxt_s   = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (bus.din_valid && bus.frame_sync) begin
                    a_nxt_s        = bus.din;
                    ch_valid_nxt_s = 4'b0001;
                    slot_nxt_s     = 2'd1;
                    state_nxt_s    = ST_LOCKED;
                end else begin
                    state_nxt_s    = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (bus.din_valid && bus.frame_sync) begin
                    // A sync always restarts the frame at slot a; only a sync
                    // arriving away from slot 0 is flagged as an error.
                    a_nxt_s        = bus.din;
                    ch_valid_nxt_s = 4'b0001;
                    slot_nxt_s     = 2'd1;
                    sync_err_nxt_s = (slot_r != 2'd0);
                end else if (bus.din_valid) begin
                    slot_nxt_s = slot_r + 2'd1;
                    case (slot_r)
                        2'd0: begin
                            a_nxt_s        = bus.din;
                            ch_valid_nxt_s = 4'b0001;
                        end
                        2'd1: begin
                            b_nxt_s        = bus.din;
                            ch_valid_nxt_s = 4'b0010;
                        end
                        2'd2: begin
                            c_nxt_s        = bus.din;
                            ch_valid_nxt_s = 4'b0100;
                        end
                        2'd3: begin
                            d_nxt_s          = bus.din;
                            ch_valid_nxt_s   = 4'b1000;
                            frame_done_nxt_s = 1'b1;
                        end
                        default: begin
                            ch_valid_nxt_s = 4'b0000;
                        end
                    endcase
                end else begin
                    slot_nxt_s = slot_r;
                end
            end
            default: begin
                state_nxt_s = ST_HUNT;
                slot_nxt_s  = 2'd0;
            end
        endcase
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_HUNT;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            c_r          <= {WIDTH{1'b0}};
            d_r          <= {WIDTH{1'b0}};
            ch_valid_r   <= 4'b0000;
            slot_r       <= 2'd0;
            locked_r     <= 1'b0;
            frame_done_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            a_r          <= a_nxt_s;
            b_r          <= b_nxt_s;
            c_r          <= c_nxt_s;
            d_r          <= d_nxt_s;
            ch_valid_r   <= ch_valid_nxt_s;
            slot_r       <= slot_nxt_s;
            locked_r     <= locked_nxt_s;
            frame_done_r <= frame_done_nxt_s;
            sync_err_r   <= sync_err_nxt_s;
        end
    end

    assign bus.a          = a_r;
    assign bus.b          = b_r;
    assign bus.c          = c_r;
    assign bus.d          = d_r;
    assign bus.ch_valid   = ch_valid_r;
    assign bus.slot       = slot_r;
    assign bus.locked     = locked_r;
    assign bus.frame_done = frame_done_r;
    assign bus.sync_err   = sync_err_r;
endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: a channel-array model checked every cycle, plus
// hand-computed literal expectations along directed scenarios.
module tb_tdm_demux4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   chk_en   = 1'b0;

    tdm_demux4_if #(.WIDTH(8)) bus ();

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: channel array indexed by slot, plain integer slot counter.
    logic [7:0] m_ch [4];
    int         m_slot   = 0;
    bit         m_locked = 1'b0;
    logic [3:0] m_strobe = 4'b0000;
    bit         m_fd     = 1'b0;
    bit         m_err    = 1'b0;

    function automatic int pick(input bit sync, input int s);
        return sync ? 0 : s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model, updated from the same inputs the DUT samples.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_ch[i] <= 8'h00;
            m_slot   <= 0;
            m_locked <= 1'b0;
            m_strobe <= 4'b0000;
            m_fd     <= 1'b0;
            m_err    <= 1'b0;
        end else begin
            m_strobe <= 4'b0000;
            m_fd     <= 1'b0;
            m_err    <= 1'b0;
            if (bus.din_valid) begin
                if (!m_locked) begin
                    if (bus.frame_sync) begin
                        m_ch[0]  <= bus.din;
                        m_strobe <= 4'b0001;
                        m_slot   <= 1;
                        m_locked <= 1'b1;
                    end
                end else begin
                    m_ch[pick(bus.frame_sync, m_slot)] <= bus.din;
                    m_strobe <= 4'(1 << pick(bus.frame_sync, m_slot));
                    m_slot   <= (pick(bus.frame_sync, m_slot) + 1) % 4;
                    m_err    <= bus.frame_sync && (m_slot != 0);
                    m_fd     <= (pick(bus.frame_sync, m_slot) == 3);
                end
            end
        end
    end

    // Compare process: every output against the model, away from the edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_a",          32'(bus.a),          32'(m_ch[0]));
            chk("cyc_b",          32'(bus.b),          32'(m_ch[1]));
            chk("cyc_c",          32'(bus.c),          32'(m_ch[2]));
            chk("cyc_d",          32'(bus.d),          32'(m_ch[3]));
            chk("cyc_ch_valid",   32'(bus.ch_valid),   32'(m_strobe));
            chk("cyc_slot",       32'(bus.slot),       32'(m_slot));
            chk("cyc_locked",     32'(bus.locked),     32'(m_locked));
            chk("cyc_frame_done", 32'(bus.frame_done), 32'(m_fd));
            chk("cyc_sync_err",   32'(bus.sync_err),   32'(m_err));
        end
    end

    // One clock with the given inputs; returns shortly after the edge.
    task automatic cycle(input logic r, input logic [7:0] dv, input logic v, input logic s);
        rst            = r;
        bus.din        = dv;
        bus.din_valid  = v;
        bus.frame_sync = s;
        @(posedge clk);
        #2;
    endtask

    initial begin
        bus.din        = 8'h00;
        bus.din_valid  = 1'b0;
        bus.frame_sync = 1'b0;

        // 1 reset with busy inputs
        cycle(1'b1, 8'hFF, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b1, 1'b1);
        chk_en = 1'b1;
        chk("rst_a", 32'(bus.a), 32'h0);
        chk("rst_d", 32'(bus.d), 32'h0);
        chk("rst_locked", 32'(bus.locked), 32'h0);
        chk("rst_ch_valid", 32'(bus.ch_valid), 32'h0);

        // 2 hunt ignores unsynced samples, then locks
        cycle(1'b0, 8'h11, 1'b1, 1'b0);
        cycle(1'b0, 8'h22, 1'b1, 1'b0);
        chk("hunt_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("hunt_a", 32'(bus.a), 32'h0);
        cycle(1'b0, 8'h33, 1'b1, 1'b1);
        chk("lock_a", 32'(bus.a), 32'h33);
        chk("lock_ch_valid", 32'(bus.ch_valid), 32'h1);
        chk("lock_locked", 32'(bus.locked), 32'h1);
        chk("lock_slot", 32'(bus.slot), 32'h1);
        chk("model_lock_a", 32'(m_ch[0]), 32'h33);
        cycle(1'b0, 8'h44, 1'b1, 1'b0);
        cycle(1'b0, 8'h55, 1'b1, 1'b0);
        cycle(1'b0, 8'h66, 1'b1, 1'b0);
        chk("fill_d", 32'(bus.d), 32'h66);
        chk("fill_slot", 32'(bus.slot), 32'h0);

        // 3 full frame back to back
        cycle(1'b0, 8'h0A, 1'b1, 1'b1);
        chk("f_sv0", 32'(bus.ch_valid), 32'h1);
        chk("f_err0", 32'(bus.sync_err), 32'h0);
        cycle(1'b0, 8'h0B, 1'b1, 1'b0);
        chk("f_sv1", 32'(bus.ch_valid), 32'h2);
        cycle(1'b0, 8'h0C, 1'b1, 1'b0);
        chk("f_sv2", 32'(bus.ch_valid), 32'h4);
        cycle(1'b0, 8'h0D, 1'b1, 1'b0);
        chk("f_sv3", 32'(bus.ch_valid), 32'h8);
        chk("f_done", 32'(bus.frame_done), 32'h1);
        chk("f_slot", 32'(bus.slot), 32'h0);
        chk("f_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h0A0B0C0D);

        // 4 same frame with gaps; a sync without valid is ignored
        cycle(1'b0, 8'h1A, 1'b1, 1'b1);
        cycle(1'b0, 8'hEE, 1'b0, 1'b1);
        chk("gap_ch_valid", 32'(bus.ch_valid), 32'h0);
        chk("gap_slot", 32'(bus.slot), 32'h1);
        cycle(1'b0, 8'h1B, 1'b1, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0, 1'b0);
        chk("gap2_slot", 32'(bus.slot), 32'h2);
        cycle(1'b0, 8'h1C, 1'b1, 1'b0);
        cycle(1'b0, 8'hEE, 1'b0, 1'b0);
        cycle(1'b0, 8'h1D, 1'b1, 1'b0);
        chk("gap_done", 32'(bus.frame_done), 32'h1);
        chk("gap_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h1A1B1C1D);

        // free-run: no sync at slot 0 still writes a, no error
        cycle(1'b0, 8'h2A, 1'b1, 1'b0);
        chk("free_a", 32'(bus.a), 32'h2A);
        chk("free_err", 32'(bus.sync_err), 32'h0);
        cycle(1'b0, 8'h2B, 1'b1, 1'b0);
        cycle(1'b0, 8'h2C, 1'b1, 1'b0);
        cycle(1'b0, 8'h2D, 1'b1, 1'b0);

        // 5 resync mid-frame
        cycle(1'b0, 8'h01, 1'b1, 1'b1);
        cycle(1'b0, 8'h02, 1'b1, 1'b0);
        cycle(1'b0, 8'h03, 1'b1, 1'b1);
        chk("rs_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h03022C2D);
        chk("rs_err", 32'(bus.sync_err), 32'h1);
        chk("rs_slot", 32'(bus.slot), 32'h1);
        chk("rs_done", 32'(bus.frame_done), 32'h0);
        chk("rs_ch_valid", 32'(bus.ch_valid), 32'h1);
        chk("model_rs_err", 32'(m_err), 32'h1);

        // 6 reset mid-frame
        cycle(1'b0, 8'h5A, 1'b1, 1'b1);
        cycle(1'b0, 8'h5B, 1'b1, 1'b0);
        chk("pre_rst_ab", {16'h0, bus.a, bus.b}, 32'h5A5B);
        cycle(1'b1, 8'h99, 1'b1, 1'b1);
        chk("mid_rst_abcd", {bus.a, bus.b, bus.c, bus.d}, 32'h0);
        chk("mid_rst_locked", 32'(bus.locked), 32'h0);
        cycle(1'b0, 8'h77, 1'b1, 1'b0);
        chk("post_rst_a", 32'(bus.a), 32'h0);
        chk("post_rst_ch_valid", 32'(bus.ch_valid), 32'h0);
        cycle(1'b0, 8'h88, 1'b1, 1'b1);
        chk("relock_a", 32'(bus.a), 32'h88);
        chk("relock_err", 32'(bus.sync_err), 32'h0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
